// File: rtl/tcdm_arb_pkg.sv
// Shared configuration and types for the TCDM round-robin arbiter slice.
package tcdm_arb_pkg;

  localparam int N_MASTERS = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_OUT   = 2;
  localparam int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } tcdm_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              opc;
  } tcdm_rsp_t;

  // Round-robin successor, wrapping the last master back to master 0.
  function automatic idx_t next_idx(input idx_t i);
    if (i == idx_t'(N_MASTERS - 1)) begin
      return idx_t'(0);
    end else begin
      return i + idx_t'(1);
    end
  endfunction

endpackage

// File: rtl/tcdm_rr_arbiter_if.sv
// TCDM bus bundle; N_PORTS request lanes with a broadcast response data/opc.
interface tcdm_rr_arbiter_if #(
  parameter int N_PORTS = 1,
  parameter int ADDR_W  = tcdm_arb_pkg::ADDR_W,
  parameter int DATA_W  = tcdm_arb_pkg::DATA_W
) ();

  logic [N_PORTS-1:0]                   req;
  logic [N_PORTS-1:0][ADDR_W-1:0]       add;
  logic [N_PORTS-1:0]                   wen;
  logic [N_PORTS-1:0][DATA_W-1:0]       wdata;
  logic [N_PORTS-1:0][DATA_W/8-1:0]     be;
  logic [N_PORTS-1:0]                   gnt;
  logic [N_PORTS-1:0]                   r_valid;
  logic [DATA_W-1:0]                    r_rdata;
  logic                                 r_opc;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata, r_opc
  );

endinterface

// File: rtl/tcdm_arb_id_fifo.sv
// In-order FIFO of granted master indices; head names the owner of the next response.
module tcdm_arb_id_fifo
  import tcdm_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  idx_t i_din,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output idx_t o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  idx_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_empty   = (r_cnt == CNT_W'(0));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Storage, pointers and occupancy count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= idx_t'(0);
      end
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_cnt    <= CNT_W'(0);
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM slave among N_MASTERS masters, with in-order response routing.
module tcdm_rr_arbiter
  import tcdm_arb_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  tcdm_rr_arbiter_if.slave      m_if,
  tcdm_rr_arbiter_if.master     s_if,
  input  logic                  i_clr_err,
  output logic                  o_err_unexp
);

  idx_t                 r_ptr;
  logic                 r_lock;
  idx_t                 r_lock_idx;
  logic                 r_err_unexp;

  idx_t                 w_winner;
  logic                 w_s_req;
  logic                 w_hs;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  idx_t                 w_head;
  tcdm_req_t            w_sel;
  tcdm_rsp_t            w_rsp;
  logic [N_MASTERS-1:0] w_gnt;
  logic [N_MASTERS-1:0] w_r_valid;

  // Winner selection: a held lock wins while its master still requests, else round-robin from r_ptr.
  always_comb begin : p_arb
    logic [IDX_W:0] v_sum;
    v_sum    = '0;
    w_winner = r_ptr;
    if (r_lock && m_if.req[r_lock_idx]) begin
      w_winner = r_lock_idx;
    end else begin
      // Scan from farthest to nearest so the closest requester at/after r_ptr is written last.
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        v_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
        v_sum = (v_sum >= (IDX_W+1)'(N_MASTERS)) ? v_sum - (IDX_W+1)'(N_MASTERS) : v_sum;
        if (m_if.req[v_sum[IDX_W-1:0]]) begin
          w_winner = v_sum[IDX_W-1:0];
        end else begin
          w_winner = w_winner;
        end
      end
    end
  end

  assign w_s_req = (|m_if.req) & ~w_full;
  assign w_hs    = w_s_req & s_if.gnt[0];
  assign w_pop   = s_if.r_valid[0] & ~w_empty;

  // Request mux and grant/response one-hot decode.
  always_comb begin
    w_sel     = '0;
    w_gnt     = '0;
    w_r_valid = '0;
    if (w_s_req) begin
      w_sel.add   = m_if.add[w_winner];
      w_sel.wen   = m_if.wen[w_winner];
      w_sel.wdata = m_if.wdata[w_winner];
      w_sel.be    = m_if.be[w_winner];
    end else begin
      w_sel = '0;
    end
    if (w_hs) begin
      w_gnt[w_winner] = 1'b1;
    end else begin
      w_gnt = '0;
    end
    if (w_pop) begin
      w_r_valid[w_head] = 1'b1;
    end else begin
      w_r_valid = '0;
    end
  end

  assign w_rsp.rdata = s_if.r_rdata;
  assign w_rsp.opc   = s_if.r_opc;

  assign s_if.req[0]   = w_s_req;
  assign s_if.add[0]   = w_sel.add;
  assign s_if.wen[0]   = w_sel.wen;
  assign s_if.wdata[0] = w_sel.wdata;
  assign s_if.be[0]    = w_sel.be;

  assign m_if.gnt      = w_gnt;
  assign m_if.r_valid  = w_r_valid;
  assign m_if.r_rdata  = w_rsp.rdata;
  assign m_if.r_opc    = w_rsp.opc;
  assign o_err_unexp   = r_err_unexp;

  tcdm_arb_id_fifo #(.DEPTH(MAX_OUT)) u_id_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_hs),
    .i_din   (w_winner),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Round-robin pointer, stall lock and sticky unexpected-response flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= idx_t'(0);
      r_lock      <= 1'b0;
      r_lock_idx  <= idx_t'(0);
      r_err_unexp <= 1'b0;
    end else begin
      if (w_hs) begin
        r_ptr  <= next_idx(w_winner);
        r_lock <= 1'b0;
      end else if (w_s_req) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_winner;
      end else begin
        r_lock <= 1'b0;
      end
      // Setting takes priority over a same-cycle clear.
      if (s_if.r_valid[0] && w_empty) begin
        r_err_unexp <= 1'b1;
      end else if (i_clr_err) begin
        r_err_unexp <= 1'b0;
      end else begin
        r_err_unexp <= r_err_unexp;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Scoreboard bench for tcdm_rr_arbiter: directed stimulus queues expected grants/responses, a monitor checks them.
module tb_tcdm_rr_arbiter;
  import tcdm_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_err = 1'b0;
  logic stall = 1'b0;
  logic hold = 1'b0;
  logic inj = 1'b0;
  logic err_unexp;
  logic rv_model;
  int   pend;
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_gnt[$];
  int   exp_rsp[$];

  always #5 clk = ~clk;

  tcdm_rr_arbiter_if #(.N_PORTS(N_MASTERS)) m_if ();
  tcdm_rr_arbiter_if #(.N_PORTS(1))         s_if ();

  tcdm_rr_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .m_if        (m_if),
    .s_if        (s_if),
    .i_clr_err   (clr_err),
    .o_err_unexp (err_unexp)
  );

  // Fixed-latency slave: grants unless stalled, answers one cycle after each grant unless held.
  assign s_if.gnt[0]     = s_if.req[0] & ~stall;
  assign rv_model        = (pend > 0) && !hold;
  assign s_if.r_valid[0] = rv_model | inj;
  assign s_if.r_rdata    = 32'hDEAD_BEEF;
  assign s_if.r_opc      = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 0;
    else        pend <= pend + ((s_if.req[0] & s_if.gnt[0]) ? 1 : 0) - (rv_model ? 1 : 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input int m);
    exp_gnt.push_back(m);
    exp_rsp.push_back(m);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a response.
  always @(negedge clk) begin : mon
    int e;
    if (rst_n) begin
      if (|m_if.gnt) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(m_if.gnt), 32'h0);
        else begin
          e = exp_gnt.pop_front();
          chk("gnt_order", 32'(m_if.gnt), 32'h1 << e);
        end
      end
      if (|m_if.r_valid) begin
        if (exp_rsp.size() == 0) chk("rvalid_unexpected", 32'(m_if.r_valid), 32'h0);
        else begin
          e = exp_rsp.pop_front();
          chk("rvalid_route", 32'(m_if.r_valid), 32'h1 << e);
          chk("rdata", m_if.r_rdata, 32'hDEAD_BEEF);
          chk("opc", 32'(m_if.r_opc), 32'h1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    m_if.req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_if.add[i]   = 32'h0000_1000 + 32'(i) * 32'h100;
      m_if.wen[i]   = 1'b1;
      m_if.wdata[i] = 32'(i);
      m_if.be[i]    = 4'hF;
    end

    // Reset state
    cyc(); #2;
    chk("rst_s_req", 32'(s_if.req[0]), 32'h0);
    chk("rst_s_add", s_if.add[0], 32'h0);
    chk("rst_gnt", 32'(m_if.gnt), 32'h0);
    chk("rst_err", 32'(err_unexp), 32'h0);
    cyc(); rst_n = 1'b1;
    cyc(); #2;
    chk("idle_s_req", 32'(s_if.req[0]), 32'h0);

    // 1: master 2, two reads
    push_both(2); push_both(2);
    cyc(); m_if.req = 4'b0100; #2;
    chk("t1_s_req", 32'(s_if.req[0]), 32'h1);
    chk("t1_s_add", s_if.add[0], 32'h0000_1200);
    chk("t1_s_wdata", s_if.wdata[0], 32'h2);
    cyc();
    cyc(); m_if.req = '0;
    cyc(); cyc();

    // 2: all masters for 8 cycles from a fresh pointer
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) push_both(k % 4);
    cyc(); m_if.req = 4'b1111;
    repeat (7) cyc();
    cyc(); m_if.req = '0;
    cyc(); cyc();

    // 3: stalled master 1 keeps the slave lane while master 0 arrives
    push_both(1); push_both(0);
    cyc(); stall = 1'b1; m_if.req = 4'b0010; #2;
    chk("t3_s_req", 32'(s_if.req[0]), 32'h1);
    cyc(); m_if.req = 4'b0011; #2;
    chk("t3_lock_add_a", s_if.add[0], 32'h0000_1100);
    cyc(); #2;
    chk("t3_lock_add_b", s_if.add[0], 32'h0000_1100);
    cyc(); stall = 1'b0; #2;
    chk("t3_lock_add_c", s_if.add[0], 32'h0000_1100);
    cyc(); m_if.req = 4'b0001; #2;
    chk("t3_m0_add", s_if.add[0], 32'h0000_1000);
    cyc(); m_if.req = '0;
    cyc();

    // 4: outstanding limit blocks the third request until a response arrives
    push_both(0); push_both(0); push_both(0);
    cyc(); hold = 1'b1; m_if.req = 4'b0001;
    cyc();
    cyc(); #2;
    chk("t4_full_block_a", 32'(s_if.req[0]), 32'h0);
    cyc(); #2;
    chk("t4_full_block_b", 32'(s_if.req[0]), 32'h0);
    cyc(); hold = 1'b0; #2;
    chk("t4_full_block_c", 32'(s_if.req[0]), 32'h0);
    cyc(); #2;
    chk("t4_unblocked", 32'(s_if.req[0]), 32'h1);
    cyc(); m_if.req = '0;
    cyc(); cyc();

    // 5: unexpected response with empty FIFO
    cyc(); inj = 1'b1; #2;
    chk("t5_no_rvalid", 32'(m_if.r_valid), 32'h0);
    cyc(); inj = 1'b0; #2;
    chk("t5_err_set", 32'(err_unexp), 32'h1);
    cyc(); #2;
    chk("t5_err_sticky", 32'(err_unexp), 32'h1);
    cyc(); clr_err = 1'b1;
    cyc(); clr_err = 1'b0; #2;
    chk("t5_err_clr", 32'(err_unexp), 32'h0);
    cyc(); inj = 1'b1; clr_err = 1'b1;
    cyc(); inj = 1'b0; clr_err = 1'b0; #2;
    chk("t5_set_wins", 32'(err_unexp), 32'h1);
    cyc(); clr_err = 1'b1;
    cyc(); clr_err = 1'b0; #2;
    chk("t5_err_clr2", 32'(err_unexp), 32'h0);

    // 6: reset with two outstanding, then masters 3 and 0 compete
    exp_gnt.push_back(2); exp_gnt.push_back(2);
    cyc(); hold = 1'b1; m_if.req = 4'b0100;
    cyc();
    cyc(); m_if.req = '0; rst_n = 1'b0; #2;
    chk("t6_rst_s_req", 32'(s_if.req[0]), 32'h0);
    cyc(); rst_n = 1'b1; hold = 1'b0; #2;
    chk("t6_err_clear", 32'(err_unexp), 32'h0);
    push_both(0);
    cyc(); m_if.req = 4'b1001; #2;
    chk("t6_winner_add", s_if.add[0], 32'h0000_1000);
    cyc(); m_if.req = '0;
    cyc(); cyc();

    chk("exp_gnt_drained", 32'(exp_gnt.size()), 32'h0);
    chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
